tl_tx_flow_control_gate: RTL and testbench
==========================================

# tl_tx_flow_control_gate

Transmit-side flow-control credit gate for the Transaction Layer TX path. It tracks the credit limit advertised by the link partner, as delivered by the DLL in InitFC/UpdateFC, and the credits consumed by transmitted TLPs, separately for Posted, Non-Posted and Completion. A TLP is released to the TX arbiter only when enough header and data credits are available. This block sits between the TX TLP scheduler and the DLL interface; it is the counterpart of the RX flow-control error checker.

## Interface
- FC_HDR_CREDS_WIDTH, 12, width of header credit-limit and credits-consumed counters.
- FC_DATA_CREDS_WIDTH, 16, width of data credit-limit and credits-consumed counters.
- DLL_HDR_CREDS_WIDTH, 8, raw HdrFC field width from the DLL.
- DLL_DATA_CREDS_WIDTH, 12, raw DataFC field width from the DLL.
- TLP_DATA_CREDS_WIDTH, 9, width of the per-TLP data credit request (max 256 credits = 4 KB).

Ports:
- clk  in  1  single clock.
- arst_n  in  1  asynchronous, active-low reset.
- dll_valid  in  1  one-cycle strobe: an FC DLLP (InitFC or UpdateFC) has been received.
- dll_typ  in  2  00 P, 01 NP, 10 CPL, 11 reserved.
- dll_hdr_creds  in  DLL_HDR_CREDS_WIDTH  HdrFC field.
- dll_data_creds  in  DLL_DATA_CREDS_WIDTH  DataFC field.
- dll_hdr_scale  in  2  HdrScale.
- dll_data_scale  in  2  DataScale.
- tlp_req  in  1  request to transmit one TLP; held until tlp_grant.
- tlp_typ  in  2  FC type of the TLP, with the same encoding as dll_typ.
- tlp_data_creds  in  TLP_DATA_CREDS_WIDTH  data credits needed; 0 means no payload.
- tlp_grant  out  1  one-cycle pulse: credits reserved, TLP may be sent.
- tlp_typ_err  out  1  one-cycle pulse: request with tlp_typ=11 was rejected.
- fc_blocked  out  1  the pending request is stalled for lack of credits or lack of init.
- fc_init_done  out  3  per-type initialized flags: bit0 P, bit1 NP, bit2 CPL.

## Operation
**Scaling.** The received value is shifted left by 0 for scale 00 or 01, by 2 for scale 10, and by 4 for scale 11. The result is zero-extended to the counter width and becomes the new credit limit (CL).

**Per-type credit state** (registers):
- CL_hdr and CL_data.
- CC_hdr and CC_data (credits consumed).
- inf_hdr and inf_data.
- init flag.

**FC DLLP handling.** When dll_valid=1 and dll_typ≠11:
- If the type is not yet initialized: load CL_hdr and CL_data, set the init flag, and set inf_hdr/inf_data wherever the raw field is 0. This is the infinite-credit rule.
- If the type is already initialized: load each CL field unless its inf flag is set. A field whose inf flag is set is never updated again.
- dll_typ=11 is ignored.

**Sufficiency test** (all arithmetic modulo 2^W, where W is the counter width):
- Header is OK when inf_hdr=1, or when (CL_hdr − (CC_hdr + 1)) mod 2^W ≤ 2^(W−1).
- Data is OK when inf_data=1, or tlp_data_creds=0, or (CL_data − (CC_data + tlp_data_creds)) mod 2^W ≤ 2^(W−1).
- The request passes only when the type is initialized, header is OK and data is OK.

**Request FSM** (states IDLE, CHECK, GRANT):
- IDLE: if tlp_req=1, latch tlp_typ and tlp_data_creds. If the latched type is 11, pulse tlp_typ_err and stay in IDLE. Otherwise go to CHECK.
- CHECK: evaluate the sufficiency test against the registered CL/CC.
  - Pass: go to GRANT.
  - Fail: stay in CHECK with fc_blocked=1.
  - tlp_req=0 (requester abort): return to IDLE with no credits consumed.
- GRANT: assert tlp_grant. Add CC_hdr += 1 and CC_data += latched data credits; both wrap modulo 2^W and are skipped for a field whose inf flag is set. Go to IDLE unconditionally.

**Simultaneous events.**
- An FC update and a GRANT on the same type in the same cycle both take effect; CL and CC are independent registers.
- A CL update made while in CHECK is visible on the next evaluation.

**Reset.** Mid-operation reset returns the FSM to IDLE and clears all CL, CC, inf and init registers. A requester that was waiting is not granted.

## Timing
- Reset values: tlp_grant=0, tlp_typ_err=0, fc_blocked=0, fc_init_done=000, FSM in IDLE.
- All outputs are registered or decoded from the FSM state; there is no combinational path from inputs to outputs.
- tlp_req is first sampled high at edge k → CHECK during cycle k+1 → earliest tlp_grant is high during cycle k+2.
- tlp_typ_err is high during cycle k+1.
- Requester rules:
  - Hold tlp_req, tlp_typ and tlp_data_creds stable until tlp_grant.
  - Drop tlp_req on the edge that ends the grant cycle.
  - A new request may be raised the following cycle.
- Maximum throughput is one grant per 3 cycles.
- fc_init_done[t] rises the cycle after the first valid FC DLLP for type t.
- A CL change takes effect on the cycle after dll_valid.

## Test plan
- **Reset and initial block.** Release reset, then raise tlp_req with tlp_typ=P and no FC received → fc_blocked=1 and no grant. Then send InitFC P with hdr=4, data=16 and scale 01 → tlp_grant exactly once, and CC_hdr=1 afterwards.
- **Header exhaustion.** After P init with hdr=2, send 3 header-only requests → the first two are granted and the third stalls with fc_blocked=1. Send UpdateFC P hdr=3 → the third is granted on the second cycle after dll_valid.
- **Scaling and data.** Send InitFC NP with data=5 and data_scale=11 (CL_data=80). A request of 80 credits is granted; the next request of 1 credit is blocked.
- **Infinite credits.** Send InitFC CPL with hdr=0 and data=0, then issue 5000 requests of 256 credits each → all are granted. A later UpdateFC CPL hdr=1 is ignored and requests are still granted.
- **Wrap-around.** Preload through updates so that CC_data=0xFFF0 and CL_data=0x0008 (mod 2^16) → a request of 24 credits is granted, CC_data wraps to 0x0008, and a further request of 1 credit is blocked.
- **Edge cases.**
  - Request with tlp_typ=11 → tlp_typ_err pulse and no grant.
  - Dropping tlp_req while in CHECK → back to IDLE with CC unchanged.
  - Asserting arst_n low while in CHECK → all outputs return to reset values and fc_init_done=000.

Source files
------------

// File: rtl/tl_tx_flow_control_gate_if.sv
// Bundle between the TX TLP scheduler / DLL FC receiver and the TX flow-control credit gate.
// The gate is the slave side; the master drives FC DLLP fields and TLP requests.
interface tl_tx_flow_control_gate_if #(
    parameter int unsigned DLL_HDR_CREDS_WIDTH  = 8,
    parameter int unsigned DLL_DATA_CREDS_WIDTH = 12,
    parameter int unsigned TLP_DATA_CREDS_WIDTH = 9
);
    logic                            dll_valid;
    logic [1:0]                      dll_typ;
    logic [DLL_HDR_CREDS_WIDTH-1:0]  dll_hdr_creds;
    logic [DLL_DATA_CREDS_WIDTH-1:0] dll_data_creds;
    logic [1:0]                      dll_hdr_scale;
    logic [1:0]                      dll_data_scale;

    logic                            tlp_req;
    logic [1:0]                      tlp_typ;
    logic [TLP_DATA_CREDS_WIDTH-1:0] tlp_data_creds;
    logic                            tlp_grant;
    logic                            tlp_typ_err;
    logic                            fc_blocked;
    logic [2:0]                      fc_init_done;

    modport master (
        output dll_valid, dll_typ, dll_hdr_creds, dll_data_creds, dll_hdr_scale, dll_data_scale,
        output tlp_req, tlp_typ, tlp_data_creds,
        input  tlp_grant, tlp_typ_err, fc_blocked, fc_init_done
    );

    modport slave (
        input  dll_valid, dll_typ, dll_hdr_creds, dll_data_creds, dll_hdr_scale, dll_data_scale,
        input  tlp_req, tlp_typ, tlp_data_creds,
        output tlp_grant, tlp_typ_err, fc_blocked, fc_init_done
    );
endinterface

// File: rtl/tl_tx_flow_control_gate.sv
// TX flow-control credit gate: tracks partner credit limits and consumed credits per P/NP/CPL
// and releases a TLP only when enough header and data credits remain.
module tl_tx_flow_control_gate #(
    parameter int unsigned FC_HDR_CREDS_WIDTH   = 12,
    parameter int unsigned FC_DATA_CREDS_WIDTH  = 16,
    parameter int unsigned TLP_DATA_CREDS_WIDTH = 9
) (
    input logic                      clk,
    input logic                      arst_n,
    tl_tx_flow_control_gate_if.slave bus
);
    localparam int unsigned HW = FC_HDR_CREDS_WIDTH;
    localparam int unsigned DW = FC_DATA_CREDS_WIDTH;
    localparam logic [HW-1:0] HDR_HALF  = HW'(1) << (HW - 1);
    localparam logic [DW-1:0] DATA_HALF = DW'(1) << (DW - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StGrant} state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      req_typ_q, req_typ_d;
    logic [TLP_DATA_CREDS_WIDTH-1:0] req_data_q, req_data_d;
    logic                            typ_err_q, typ_err_d;

    logic [HW-1:0] cl_hdr_q [3];
    logic [HW-1:0] cl_hdr_d [3];
    logic [HW-1:0] cc_hdr_q [3];
    logic [HW-1:0] cc_hdr_d [3];
    logic [DW-1:0] cl_data_q [3];
    logic [DW-1:0] cl_data_d [3];
    logic [DW-1:0] cc_data_q [3];
    logic [DW-1:0] cc_data_d [3];
    logic [2:0]    inf_hdr_q, inf_hdr_d;
    logic [2:0]    inf_data_q, inf_data_d;
    logic [2:0]    init_q, init_d;

    logic [1:0]    dll_idx;
    logic [HW-1:0] dll_hdr_scaled;
    logic [DW-1:0] dll_data_scaled;
    logic [HW-1:0] hdr_room;
    logic [DW-1:0] data_room;
    logic          hdr_ok, data_ok, pass;

    // Scale 00 behaves like 01 so legacy partners without scaling still work.
    function automatic int unsigned scale_shift(input logic [1:0] scale);
        case (scale)
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    assign dll_idx         = bus.dll_typ;
    assign dll_hdr_scaled  = HW'(bus.dll_hdr_creds) << scale_shift(bus.dll_hdr_scale);
    assign dll_data_scaled = DW'(bus.dll_data_creds) << scale_shift(bus.dll_data_scale);

    // Modular window test: remaining room must lie in the lower half of the counter space.
    always_comb begin
        hdr_room  = cl_hdr_q[req_typ_q] - (cc_hdr_q[req_typ_q] + HW'(1));
        data_room = cl_data_q[req_typ_q] - (cc_data_q[req_typ_q] + DW'(req_data_q));
        hdr_ok    = inf_hdr_q[req_typ_q] || (hdr_room <= HDR_HALF);
        data_ok   = inf_data_q[req_typ_q] || (req_data_q == '0) || (data_room <= DATA_HALF);
        pass      = init_q[req_typ_q] && hdr_ok && data_ok;
    end

    always_comb begin
        state_d    = state_q;
        req_typ_d  = req_typ_q;
        req_data_d = req_data_q;
        typ_err_d  = 1'b0;
        cl_hdr_d   = cl_hdr_q;
        cc_hdr_d   = cc_hdr_q;
        cl_data_d  = cl_data_q;
        cc_data_d  = cc_data_q;
        inf_hdr_d  = inf_hdr_q;
        inf_data_d = inf_data_q;
        init_d     = init_q;

        if (bus.dll_valid && (bus.dll_typ != 2'b11)) begin
            if (!init_q[dll_idx]) begin
                cl_hdr_d[dll_idx]   = dll_hdr_scaled;
                cl_data_d[dll_idx]  = dll_data_scaled;
                init_d[dll_idx]     = 1'b1;
                inf_hdr_d[dll_idx]  = (bus.dll_hdr_creds == '0);
                inf_data_d[dll_idx] = (bus.dll_data_creds == '0);
            end else begin
                if (!inf_hdr_q[dll_idx]) cl_hdr_d[dll_idx] = dll_hdr_scaled;
                if (!inf_data_q[dll_idx]) cl_data_d[dll_idx] = dll_data_scaled;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.tlp_req) begin
                    if (bus.tlp_typ == 2'b11) begin
                        typ_err_d = 1'b1;
                    end else begin
                        req_typ_d  = bus.tlp_typ;
                        req_data_d = bus.tlp_data_creds;
                        state_d    = StCheck;
                    end
                end
            end
            StCheck: begin
                if (!bus.tlp_req) state_d = StIdle;
                else if (pass) state_d = StGrant;
            end
            StGrant: begin
                state_d = StIdle;
                if (!inf_hdr_q[req_typ_q]) begin
                    cc_hdr_d[req_typ_q] = cc_hdr_q[req_typ_q] + HW'(1);
                end
                if (!inf_data_q[req_typ_q]) begin
                    cc_data_d[req_typ_q] = cc_data_q[req_typ_q] + DW'(req_data_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            req_typ_q  <= '0;
            req_data_q <= '0;
            typ_err_q  <= 1'b0;
            cl_hdr_q   <= '{default: '0};
            cc_hdr_q   <= '{default: '0};
            cl_data_q  <= '{default: '0};
            cc_data_q  <= '{default: '0};
            inf_hdr_q  <= '0;
            inf_data_q <= '0;
            init_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_typ_q  <= req_typ_d;
            req_data_q <= req_data_d;
            typ_err_q  <= typ_err_d;
            cl_hdr_q   <= cl_hdr_d;
            cc_hdr_q   <= cc_hdr_d;
            cl_data_q  <= cl_data_d;
            cc_data_q  <= cc_data_d;
            inf_hdr_q  <= inf_hdr_d;
            inf_data_q <= inf_data_d;
            init_q     <= init_d;
        end
    end

    // fc_blocked depends only on registered state, never directly on inputs.
    assign bus.tlp_grant    = (state_q == StGrant);
    assign bus.tlp_typ_err  = typ_err_q;
    assign bus.fc_blocked   = (state_q == StCheck) && !pass;
    assign bus.fc_init_done = init_q;
endmodule

// File: tb/tb_tl_tx_flow_control_gate.sv
// Self-checking bench for tl_tx_flow_control_gate: directed scenarios plus random traffic,
// checked every cycle against a credit-accounting reference model.
module tb_tl_tx_flow_control_gate;
    localparam longint HM = 64'd1 << 12;
    localparam longint DM = 64'd1 << 16;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    tl_tx_flow_control_gate_if bus ();

    tl_tx_flow_control_gate dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int g_cnt = 0;
    int e_cnt = 0;
    bit cmp_en = 0;

    // Reference model: credit bookkeeping per type plus requester phase.
    longint mcl_h [3];
    longint mcc_h [3];
    longint mcl_d [3];
    longint mcc_d [3];
    bit     minf_h [3];
    bit     minf_d [3];
    bit     minit [3];
    int     m_phase;  // 0 waiting, 1 evaluating, 2 granting
    int     m_typ;
    longint m_creds;
    bit     m_err;
    int     m_next;
    int     mt;
    longint vh, vd;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int shamt(input longint s);
        return (s == 2) ? 2 : (s == 3) ? 4 : 0;
    endfunction

    function automatic bit model_pass(input int t, input longint n);
        longint hr, dr;
        hr = (((mcl_h[t] - mcc_h[t] - 1) % HM) + HM) % HM;
        dr = (((mcl_d[t] - mcc_d[t] - n) % DM) + DM) % DM;
        return minit[t] && (minf_h[t] || hr <= HM / 2) && (minf_d[t] || n == 0 || dr <= DM / 2);
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 3; i++) begin
                mcl_h[i] = 0; mcc_h[i] = 0; mcl_d[i] = 0; mcc_d[i] = 0;
                minf_h[i] = 0; minf_d[i] = 0; minit[i] = 0;
            end
            m_phase = 0; m_typ = 0; m_creds = 0; m_err = 0;
        end else begin
            m_next = m_phase;
            m_err  = 0;
            if (m_phase == 0) begin
                if (bus.tlp_req) begin
                    if (bus.tlp_typ == 2'b11) m_err = 1;
                    else begin
                        m_typ = int'(bus.tlp_typ); m_creds = longint'(bus.tlp_data_creds);
                        m_next = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (!bus.tlp_req) m_next = 0;
                else if (model_pass(m_typ, m_creds)) m_next = 2;
            end else begin
                m_next = 0;
                if (!minf_h[m_typ]) mcc_h[m_typ] = (mcc_h[m_typ] + 1) % HM;
                if (!minf_d[m_typ]) mcc_d[m_typ] = (mcc_d[m_typ] + m_creds) % DM;
            end
            m_phase = m_next;
            if (bus.dll_valid && bus.dll_typ != 2'b11) begin
                mt = int'(bus.dll_typ);
                vh = longint'(bus.dll_hdr_creds) << shamt(longint'(bus.dll_hdr_scale));
                vd = longint'(bus.dll_data_creds) << shamt(longint'(bus.dll_data_scale));
                if (!minit[mt]) begin
                    mcl_h[mt] = vh; mcl_d[mt] = vd; minit[mt] = 1;
                    minf_h[mt] = (bus.dll_hdr_creds == 0);
                    minf_d[mt] = (bus.dll_data_creds == 0);
                end else begin
                    if (!minf_h[mt]) mcl_h[mt] = vh;
                    if (!minf_d[mt]) mcl_d[mt] = vd;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tlp_grant", longint'(bus.tlp_grant), longint'(m_phase == 2));
            check("tlp_typ_err", longint'(bus.tlp_typ_err), longint'(m_err));
            check("fc_blocked", longint'(bus.fc_blocked),
                  longint'(m_phase == 1 && !model_pass(m_typ, m_creds)));
            check("fc_init_done", longint'(bus.fc_init_done),
                  longint'({minit[2], minit[1], minit[0]}));
            if (bus.tlp_grant === 1'b1) g_cnt++;
            if (bus.tlp_typ_err === 1'b1) e_cnt++;
        end
    end

    task automatic do_dll(input int t, input int h, input int d, input int hs, input int ds);
        bus.dll_typ = t[1:0]; bus.dll_hdr_creds = h[7:0]; bus.dll_data_creds = d[11:0];
        bus.dll_hdr_scale = hs[1:0]; bus.dll_data_scale = ds[1:0];
        bus.dll_valid = 1'b1;
        @(posedge clk);
        #1 bus.dll_valid = 1'b0;
    endtask

    task automatic start_req(input int t, input int n);
        bus.tlp_typ = t[1:0]; bus.tlp_data_creds = n[8:0]; bus.tlp_req = 1'b1;
    endtask

    task automatic wait_grant(input int max_cyc, output bit got, output int cyc, output bit err);
        got = 0; err = 0; cyc = 0;
        while (cyc < max_cyc && !got && !err) begin
            @(negedge clk);
            cyc++;
            if (bus.tlp_grant === 1'b1) begin
                got = 1;
                @(posedge clk);
                #1 bus.tlp_req = 1'b0;
            end else if (bus.tlp_typ_err === 1'b1) begin
                err = 1;
                bus.tlp_req = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        bus.tlp_req = 1'b0; bus.dll_valid = 1'b0;
        @(posedge clk);
        #1 arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  g0, e0, cyc, n, t;
        bit  got, err;
        longint cc;
        longint tgt [4];
        tgt[0] = 64'h4000; tgt[1] = 64'h8000; tgt[2] = 64'hC000; tgt[3] = 64'hFFF0;

        bus.dll_valid = 0; bus.dll_typ = 0; bus.dll_hdr_creds = 0; bus.dll_data_creds = 0;
        bus.dll_hdr_scale = 0; bus.dll_data_scale = 0;
        bus.tlp_req = 0; bus.tlp_typ = 0; bus.tlp_data_creds = 0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        cmp_en = 1;
        @(negedge clk);
        check("reset_init_done", longint'(bus.fc_init_done), 0);
        check("reset_grant", longint'(bus.tlp_grant), 0);

        // No FC yet: request stalls; InitFC P then releases it exactly once.
        g0 = g_cnt;
        start_req(0, 2);
        wait_grant(6, got, cyc, err);
        check("uninit_no_grant", longint'(got), 0);
        check("uninit_blocked", longint'(bus.fc_blocked), 1);
        do_dll(0, 4, 16, 1, 1);
        wait_grant(6, got, cyc, err);
        check("init_grant", longint'(got), 1);
        repeat (3) @(posedge clk);
        check("init_grant_once", longint'(g_cnt - g0), 1);
        check("model_cc_hdr_p", mcc_h[0], 1);

        // Header exhaustion and UpdateFC release.
        do_reset();
        do_dll(0, 2, 16, 1, 1);
        g0 = g_cnt;
        for (int i = 0; i < 3; i++) begin
            start_req(0, 0);
            wait_grant(6, got, cyc, err);
            check("hdr_exhaust_grant", longint'(got), longint'(i < 2));
        end
        check("hdr_exhaust_blocked", longint'(bus.fc_blocked), 1);
        do_dll(0, 3, 16, 1, 1);
        wait_grant(6, got, cyc, err);
        check("hdr_update_grant", longint'(got), 1);
        check("hdr_update_latency", longint'(cyc), 2);
        check("hdr_grants", longint'(g_cnt - g0), 3);

        // Data scaling and requester abort.
        do_dll(1, 10, 5, 1, 3);
        check("model_cl_data_np", mcl_d[1], 80);
        start_req(1, 80);
        wait_grant(6, got, cyc, err);
        check("np_80_grant", longint'(got), 1);
        start_req(1, 1);
        wait_grant(6, got, cyc, err);
        check("np_1_blocked", longint'(got), 0);
        check("np_1_fc_blocked", longint'(bus.fc_blocked), 1);
        bus.tlp_req = 1'b0;
        repeat (3) @(posedge clk);
        check("abort_cc_unchanged", mcc_d[1], 80);

        // Request type 11 is rejected.
        e0 = e_cnt;
        start_req(3, 4);
        wait_grant(4, got, cyc, err);
        check("typ_err_seen", longint'(err), 1);
        @(posedge clk);
        check("typ_err_once", longint'(e_cnt - e0), 1);

        // Infinite credits on CPL.
        do_dll(2, 0, 0, 1, 1);
        g0 = g_cnt;
        for (int i = 0; i < 5000; i++) begin
            start_req(2, 256);
            wait_grant(8, got, cyc, err);
            if (!got) begin
                check("inf_grant", longint'(got), 1);
                bus.tlp_req = 1'b0;
                break;
            end
        end
        do_dll(2, 1, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            start_req(2, 256);
            wait_grant(8, got, cyc, err);
            check("inf_after_update", longint'(got), 1);
        end
        check("inf_grants", longint'(g_cnt - g0), 5002);

        // Wrap-around of the data counter.
        do_reset();
        cc = 0;
        for (int s = 0; s < 4; s++) begin
            do_dll(0, 0, int'(tgt[s] >> 4), 1, 3);
            while (cc < tgt[s]) begin
                n = (tgt[s] - cc > 256) ? 256 : int'(tgt[s] - cc);
                start_req(0, n);
                wait_grant(8, got, cyc, err);
                if (!got) begin
                    check("wrap_preload", longint'(got), 1);
                    bus.tlp_req = 1'b0;
                    break;
                end
                cc += n;
            end
        end
        check("model_cc_fff0", mcc_d[0], 64'hFFF0);
        do_dll(0, 0, 8, 1, 1);
        start_req(0, 24);
        wait_grant(8, got, cyc, err);
        check("wrap_grant", longint'(got), 1);
        check("model_cc_wrapped", mcc_d[0], 8);
        start_req(0, 1);
        wait_grant(6, got, cyc, err);
        check("wrap_blocked", longint'(got), 0);

        // Reset while a blocked request is pending.
        check("pre_reset_blocked", longint'(bus.fc_blocked), 1);
        #1 arst_n = 1'b0;
        @(negedge clk);
        check("rst_blocked", longint'(bus.fc_blocked), 0);
        check("rst_init_done", longint'(bus.fc_init_done), 0);
        bus.tlp_req = 1'b0;
        @(posedge clk);
        #1 arst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            if ($urandom_range(0, 9) < 3) begin
                do_dll(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                       int'($urandom_range(0, 80)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            end else begin
                t = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                start_req(t, int'($urandom_range(0, 40)));
                if ($urandom_range(0, 3) == 0)
                    do_dll(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                           int'($urandom_range(0, 80)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)));
                wait_grant(int'($urandom_range(1, 8)), got, cyc, err);
                if (!got && !err) bus.tlp_req = 1'b0;
            end
        end
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
